// File: rtl/intr_ctrl_if.sv
// Interrupt front-end bus between the CU-side logic (master) and intr_ctrl (slave).
// Carries raw requests, enables, ack/mret pulses and the prioritized request outputs.
interface intr_ctrl_if #(
  parameter int NUM_SRC = 4
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] irq_in;
  logic               mie;
  logic [NUM_SRC-1:0] src_mask;
  logic               intr_ack;
  logic               mret;
  logic               intr;
  logic [ID_W-1:0]    intr_id;
  logic [NUM_SRC-1:0] pending;
  logic               in_service;

  modport master (
    output irq_in, mie, src_mask, intr_ack, mret,
    input  intr, intr_id, pending, in_service
  );

  modport slave (
    input  irq_in, mie, src_mask, intr_ack, mret,
    output intr, intr_id, pending, in_service
  );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt front end for the OTTER CU: sync, edge-latch, mask, prioritize, track in-service.
// Define INTR_LEVEL_EN for level-sensitive sources (pending follows the synced level).
module intr_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       RST,
  intr_ctrl_if.slave bus
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [NUM_SRC-1:0] sync_r [SYNC_STAGES];
  logic [NUM_SRC-1:0] synced_s;
  logic [NUM_SRC-1:0] pending_s;
  logic [NUM_SRC-1:0] elig_s;
  logic [ID_W-1:0]    id_s;
  logic               intr_s;
  logic               take_s;

  // Lowest set index wins; an empty vector yields index 0.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = ID_W'(i);
      end
    end
    return idx;
  endfunction

  // Multi-stage synchronizer chain per source
  always_ff @(posedge clk) begin
    if (!RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= {NUM_SRC{1'b0}};
      end
    end else begin
      sync_r[0] <= bus.irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  assign synced_s = sync_r[SYNC_STAGES-1];

`ifdef INTR_LEVEL_EN
  assign pending_s = synced_s;
`else
  logic [NUM_SRC-1:0] hist_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] clr_s;

  assign rise_s = synced_s & ~hist_r;

  // One-hot clear of the acknowledged source
  always_comb begin
    clr_s = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_s[i] = take_s && (id_s == ID_W'(i));
    end
  end

  // Edge history and pending latch; a fresh edge beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!RST) begin
      hist_r    <= {NUM_SRC{1'b0}};
      pending_r <= {NUM_SRC{1'b0}};
    end else begin
      hist_r    <= synced_s;
      pending_r <= (pending_r & ~clr_s) | rise_s;
    end
  end

  assign pending_s = pending_r;
`endif

  assign elig_s = pending_s & bus.src_mask;
  assign id_s   = lowest_idx(elig_s);
  assign intr_s = bus.mie & (state_r == IDLE) & (|elig_s);
  assign take_s = bus.intr_ack & intr_s;

  // In-service state register
  always_ff @(posedge clk) begin
    if (!RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Ack only counts while a request is shown; mret only leaves SERVICE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_s) begin
          state_s = SERVICE;
        end else begin
          state_s = IDLE;
        end
      end
      SERVICE: begin
        if (bus.mret) begin
          state_s = IDLE;
        end else begin
          state_s = SERVICE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign bus.intr       = intr_s;
  assign bus.intr_id    = id_s;
  assign bus.pending    = pending_s;
  assign bus.in_service = (state_r == SERVICE);
endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl; expectations are queued with stimulus and popped at sampling.
// Observation vector: {intr, intr_id[1:0], pending[3:0], in_service}.
module tb_intr_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  intr_ctrl_if #(.NUM_SRC(N)) bus ();

  intr_ctrl #(.NUM_SRC(N), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [7:0] pk(logic i, logic [1:0] id, logic [3:0] p, logic s);
    return {i, id, p, s};
  endfunction

  function automatic logic [7:0] obs();
    return {bus.intr, bus.intr_id, bus.pending, bus.in_service};
  endfunction

  task automatic push(string n, logic [7:0] v);
    exp_t t;
    t.name = n;
    t.v    = v;
    exp_q.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RST          = 1'b0;
    bus.irq_in   = 4'b0000;
    bus.mie      = 1'b0;
    bus.src_mask = 4'b1111;
    bus.intr_ack = 1'b0;
    bus.mret     = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    RST          = 1'b0;
    bus.irq_in   = 4'b1111;
    bus.mie      = 1'b0;
    bus.src_mask = 4'b1111;
    bus.intr_ack = 1'b0;
    bus.mret     = 1'b0;
    push("reset_hold", pk(1'b0, 2'd0, 4'b0000, 1'b0));
    tick();
    tick();
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    RST = 1'b1;
    push("reset_edge1", pk(1'b0, 2'd0, 4'b0000, 1'b0));
    push("reset_edge2", pk(1'b0, 2'd0, 4'b0000, 1'b0));
    push("reset_edge3", pk(1'b0, 2'd0, 4'b1111, 1'b0));
    for (int k = 0; k < 3; k++) begin
      tick();
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    bus.mie    = 1'b1;
    bus.irq_in = 4'b0100;
    push("single_lat1", pk(1'b0, 2'd0, 4'b0000, 1'b0));
    push("single_lat2", pk(1'b0, 2'd0, 4'b0000, 1'b0));
    push("single_lat3", pk(1'b1, 2'd2, 4'b0100, 1'b0));
    for (int k = 0; k < 3; k++) begin
      tick();
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    end
    bus.intr_ack = 1'b1;
    push("single_ack", pk(1'b0, 2'd0, 4'b0000, 1'b1));
    tick();
    bus.intr_ack = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.mret = 1'b1;
    push("single_mret", pk(1'b0, 2'd0, 4'b0000, 1'b0));
    tick();
    bus.mret = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    push("single_level_held", pk(1'b0, 2'd0, 4'b0000, 1'b0));
    tick(); tick(); tick();
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.irq_in = 4'b0000;
  endtask

  task automatic test_priority();
    exp_t e;
    do_reset();
    bus.mie    = 1'b1;
    bus.irq_in = 4'b1010;
    push("prio_req", pk(1'b1, 2'd1, 4'b1010, 1'b0));
    tick(); tick(); tick();
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.intr_ack = 1'b1;
    push("prio_ack", pk(1'b0, 2'd3, 4'b1000, 1'b1));
    tick();
    bus.intr_ack = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.mret = 1'b1;
    push("prio_mret", pk(1'b1, 2'd3, 4'b1000, 1'b0));
    tick();
    bus.mret = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.intr_ack = 1'b1;
    push("prio_ack2", pk(1'b0, 2'd0, 4'b0000, 1'b1));
    tick();
    bus.intr_ack = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.irq_in = 4'b0000;
  endtask

  task automatic test_gating();
    exp_t e;
    do_reset();
    bus.mie      = 1'b1;
    bus.src_mask = 4'b1011;
    bus.irq_in   = 4'b0100;
    push("gate_masked", pk(1'b0, 2'd0, 4'b0100, 1'b0));
    tick(); tick(); tick();
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.src_mask = 4'b1111;
    push("gate_unmask", pk(1'b1, 2'd2, 4'b0100, 1'b0));
    #1;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.mie = 1'b0;
    push("gate_mie_off", pk(1'b0, 2'd2, 4'b0100, 1'b0));
    #1;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.intr_ack = 1'b1;
    push("gate_ack_ignored", pk(1'b0, 2'd2, 4'b0100, 1'b0));
    tick();
    bus.intr_ack = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.irq_in = 4'b0000;
  endtask

  task automatic test_collision();
    exp_t e;
    do_reset();
    bus.mie    = 1'b1;
    bus.irq_in = 4'b0001;
    tick();
    bus.irq_in = 4'b0000;
    tick();
    push("coll_first", pk(1'b1, 2'd0, 4'b0001, 1'b0));
    tick();
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.irq_in = 4'b0001;
    tick();
    tick();
    bus.intr_ack = 1'b1;
    push("coll_set_wins", pk(1'b0, 2'd0, 4'b0001, 1'b1));
    tick();
    bus.intr_ack = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.mret = 1'b1;
    push("coll_after_mret", pk(1'b1, 2'd0, 4'b0001, 1'b0));
    tick();
    bus.mret = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.irq_in = 4'b0000;
  endtask

  task automatic test_ignored();
    exp_t e;
    do_reset();
    bus.mie      = 1'b1;
    bus.intr_ack = 1'b1;
    push("ign_ack_idle", pk(1'b0, 2'd0, 4'b0000, 1'b0));
    tick();
    bus.intr_ack = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.mret = 1'b1;
    push("ign_mret_idle", pk(1'b0, 2'd0, 4'b0000, 1'b0));
    tick();
    bus.mret = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    bus.mie    = 1'b1;
    bus.irq_in = 4'b0011;
    tick(); tick(); tick();
    bus.intr_ack = 1'b1;
    push("mid_service", pk(1'b0, 2'd1, 4'b0010, 1'b1));
    tick();
    bus.intr_ack = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    RST        = 1'b0;
    bus.irq_in = 4'b0000;
    push("mid_reset", pk(1'b0, 2'd0, 4'b0000, 1'b0));
    tick();
    RST = 1'b1;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
  endtask

  task automatic test_level();
    exp_t e;
    do_reset();
    bus.mie    = 1'b1;
    bus.irq_in = 4'b0010;
    push("lvl_edge1", pk(1'b0, 2'd0, 4'b0000, 1'b0));
    push("lvl_edge2", pk(1'b1, 2'd1, 4'b0010, 1'b0));
    for (int k = 0; k < 2; k++) begin
      tick();
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    end
    bus.intr_ack = 1'b1;
    push("lvl_ack", pk(1'b0, 2'd1, 4'b0010, 1'b1));
    tick();
    bus.intr_ack = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.mret = 1'b1;
    push("lvl_mret", pk(1'b1, 2'd1, 4'b0010, 1'b0));
    tick();
    bus.mret = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    bus.irq_in = 4'b0000;
    push("lvl_drop1", pk(1'b1, 2'd1, 4'b0010, 1'b0));
    push("lvl_drop2", pk(1'b0, 2'd0, 4'b0000, 1'b0));
    for (int k = 0; k < 2; k++) begin
      tick();
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.v); end
    end
  endtask

  initial begin
    RST          = 1'b0;
    bus.irq_in   = 4'b0000;
    bus.mie      = 1'b0;
    bus.src_mask = 4'b1111;
    bus.intr_ack = 1'b0;
    bus.mret     = 1'b0;
`ifdef INTR_LEVEL_EN
    test_level();
    test_ignored();
`else
    test_reset();
    test_single();
    test_priority();
    test_gating();
    test_collision();
    test_ignored();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt front end for the OTTER core. It sits directly upstream of the control unit FSM and drives that FSM's intr input.
- It synchronizes asynchronous external interrupt requests, edge-detects them, and latches them as pending.
- It applies per-source masks and the global enable, then presents one prioritized request and its source ID to the FSM.
- It tracks the in-service state between the FSM's acknowledge and mret.

Parameters:
- NUM_SRC, 4, number of external interrupt sources (1..16).
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (≥2).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous reset, active-low; RST=0 at a posedge resets the block.
- irq_in  in  NUM_SRC  asynchronous external requests, rising-edge sensitive.
- mie  in  1  global interrupt enable (mstatus.MIE from the CSR file).
- src_mask  in  NUM_SRC  per-source enable; 1 = enabled.
- intr_ack  in  1  one-cycle pulse from the CU FSM when it enters the interrupt-entry state.
- mret  in  1  one-cycle pulse when an mret instruction executes.
- intr  out  1  interrupt request to the CU FSM.
- intr_id  out  $clog2(NUM_SRC) (min 1)  index of the highest-priority masked-pending source.
- pending  out  NUM_SRC  raw pending bits, unmasked, readable via CSR.
- in_service  out  1  high from acknowledge until mret.

Behaviour:
- Reset (RST=0 at a posedge): clears the sync chains, edge-detect history, pending, and in_service. Outputs read intr=0, intr_id=0, pending=0, in_service=0 from the following cycle.
- Synchronizer: each irq_in bit passes through SYNC_STAGES flops. An edge-history flop holds the last synced value.
- Rising edge: a rising edge is synced=1 and history=0. It sets pending[i] at the next posedge.
- Latency: irq_in rises before posedge k. pending[i] and intr (if enabled) are high after posedge k+SYNC_STAGES, i.e. 3 edges with defaults.
- Masked sources still latch pending; they only become visible once src_mask[i]=1.
- Eligible vector: elig = pending & src_mask.
- Priority: lowest index wins. intr_id = lowest set bit of elig; intr_id=0 when elig=0.
- Request: intr = mie & ~in_service & |elig. It is combinational from registered state and inputs.
- States (in_service flag):
  - IDLE: intr_ack with intr=1 → SERVICE. Pending[intr_id] clears at the same edge. intr_id is sampled in the same cycle as the ack.
  - SERVICE: mret → IDLE.
  - intr_ack while intr=0 is ignored.
  - mret while in IDLE is ignored.
- Simultaneous events:
  - A new rising edge on source i in the same cycle its ack clears it: pending[i] stays 1 (set wins).
  - mret and intr_ack in the same cycle: in_service stays 1 (ack wins). This only occurs with intr=1, which requires in_service=0, so it is effectively an ack.
- A level held high produces exactly one pending event. A new event needs the level to drop and rise again.
- Reset mid-service: in_service and pending clear unconditionally, and all requests in flight are lost.
- No nesting: while in_service=1, intr stays 0 and new edges accumulate in pending.

Optional Feature:
- Macro: INTR_LEVEL_EN.
- Defined: pending[i] directly equals the synced level. No edge detect, and intr_ack does not clear pending. The source must deassert before mret, or intr reasserts right after mret. Latency becomes SYNC_STAGES edges.
- Undefined: edge-triggered latched behaviour as described in Behaviour.

Test Plan:
1. Reset: hold RST=0 for 2 cycles with irq_in=4'b1111 → pending=0, intr=0, in_service=0. After release and first rising edges, pending=4'b1111 at edge 3.
2. Single source: mie=1, src_mask=4'b1111, irq_in[2] rises → intr=1, intr_id=2 after 3 edges. Pulse intr_ack → pending=0, in_service=1, intr=0. Pulse mret → in_service=0, intr stays 0.
3. Priority: irq_in[3] and irq_in[1] rise in the same cycle → intr_id=1. After ack, pending=4'b1000. After mret, intr=1 with intr_id=3.
4. Gating: pending=4'b0100 with src_mask=4'b1011 → intr=0. Set src_mask[2]=1 → intr=1, intr_id=2. Then set mie=0 → intr=0 with pending unchanged.
5. Collision: a fresh edge on source 0 lands in the same cycle as the intr_ack clearing source 0 → pending[0]=1 after the edge and in_service=1.
6. INTR_LEVEL_EN build: hold irq_in[1]=1 through ack and mret → pending[1] stays 1 and intr=1 one cycle after mret. Drop irq_in[1] → pending[1]=0 after 2 edges.
